// File: rtl/playback_pkg.sv
// Shared types and defaults for the sample playback source.
package playback_pkg;

  localparam int DEF_N         = 16;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_FLUSH_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // A requested length of 0, or anything beyond the buffer, plays the whole buffer.
  function automatic int unsigned eff_len(int unsigned len, int unsigned depth);
    return (len == 0 || len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/sample_buffer.sv
// DEPTH x N sample store: one synchronous write port, one combinational read port.
module sample_buffer #(
  parameter int N      = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic signed [N-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic signed [N-1:0] rd_data
);

  // Contents deliberately survive reset.
  logic signed [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_playback_source.sv
// Plays a buffer of signed samples over a valid/ready stream, looped or one-shot with zero flush.
module sample_playback_source
  import playback_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = 5,
  parameter int FLUSH_LEN = DEF_FLUSH_LEN
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic signed [N-1:0] wr_data,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [ADDR_W:0]     length,
  output logic signed [N-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                busy,
  output logic                wrap,
  output logic                done
);

  localparam int FC_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  state_t              state;
  logic [ADDR_W-1:0]   rd_idx;
  logic [ADDR_W:0]     len_q;
  logic                loop_q;
  logic [FC_W-1:0]     flush_cnt;

  logic                xfer;
  logic [ADDR_W-1:0]   rd_addr;
  logic signed [N-1:0] rd_data;
  logic [ADDR_W:0]     start_len;
  logic [ADDR_W:0]     idx_inc;
  logic [ADDR_W-1:0]   idx_next;
  logic                flush_last;

  sample_buffer #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && state == IDLE),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign xfer       = data_valid && data_ready;
  assign busy       = (state != IDLE);
  assign rd_addr    = (state == IDLE) ? '0 : rd_idx;
  assign start_len  = (ADDR_W+1)'(eff_len(32'(length), DEPTH));
  assign idx_inc    = {1'b0, rd_idx} + (ADDR_W+1)'(1);
  assign idx_next   = (idx_inc >= len_q) ? '0 : idx_inc[ADDR_W-1:0];
  assign flush_last = (flush_cnt == FC_W'(FLUSH_LEN - 1));

  // rd_idx always names the next sample to present, so rd_idx == 0 in PLAY
  // means the sample on data_out is index L-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rd_idx     <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      flush_cnt  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            len_q      <= start_len;
            loop_q     <= loop_en;
            data_out   <= rd_data;
            data_valid <= 1'b1;
            rd_idx     <= (start_len == (ADDR_W+1)'(1)) ? '0 : ADDR_W'(1);
            state      <= PLAY;
          end
        end
        PLAY: begin
          if (stop) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            data_out   <= '0;
            rd_idx     <= '0;
          end else if (xfer) begin
            if (rd_idx != '0) begin
              data_out <= rd_data;
              rd_idx   <= idx_next;
            end else if (loop_q) begin
              data_out <= rd_data;
              rd_idx   <= idx_next;
              wrap     <= 1'b1;
            end else if (FLUSH_LEN > 0) begin
              state     <= FLUSH;
              data_out  <= '0;
              flush_cnt <= '0;
            end else begin
              state      <= IDLE;
              data_valid <= 1'b0;
              data_out   <= '0;
              done       <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (stop) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            data_out   <= '0;
            flush_cnt  <= '0;
          end else if (xfer) begin
            if (flush_last) begin
              state      <= IDLE;
              data_valid <= 1'b0;
              flush_cnt  <= '0;
              done       <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt + FC_W'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
          data_out   <= '0;
        end
      endcase
    end
  end

endmodule
